// File: rtl/div_seq.sv
// Multicycle signed divider with MIPS DIV semantics: lo = A/B truncated toward zero, hi = A%B.
// One restoring step per cycle on operand magnitudes; the signs are applied in the final cycle.
module div_seq #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] value_A,
  input  logic [DATA_W-1:0] value_B,
  input  logic              divInit,
  output logic              busy,
  output logic              divStop,
  output logic              divZero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e            r_state, w_state_nxt;
  logic [CntW-1:0]   r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_rem, w_rem_nxt;
  logic [DATA_W-1:0] r_quo, w_quo_nxt;
  logic [DATA_W-1:0] r_dvs, w_dvs_nxt;
  logic              r_sign_a, w_sign_a_nxt;
  logic              r_sign_q, w_sign_q_nxt;
  logic [DATA_W-1:0] r_hi, w_hi_nxt;
  logic [DATA_W-1:0] r_lo, w_lo_nxt;
  logic              r_stop, w_stop_nxt;
  logic              r_zero, w_zero_nxt;

  logic [DATA_W-1:0] w_abs_a, w_abs_b;
  logic [DATA_W:0]   w_shift, w_trial;

  // Magnitudes as unsigned; the most negative value maps onto itself, which is exact here.
  assign w_abs_a = value_A[DATA_W-1] ? (~value_A + 1'b1) : value_A;
  assign w_abs_b = value_B[DATA_W-1] ? (~value_B + 1'b1) : value_B;

  assign w_shift = {r_rem, r_quo[DATA_W-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_rem_nxt    = r_rem;
    w_quo_nxt    = r_quo;
    w_dvs_nxt    = r_dvs;
    w_sign_a_nxt = r_sign_a;
    w_sign_q_nxt = r_sign_q;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    w_stop_nxt   = 1'b0;
    w_zero_nxt   = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (divInit) begin
          if (value_B == '0) begin
            w_zero_nxt = 1'b1;
          end else begin
            w_sign_a_nxt = value_A[DATA_W-1];
            w_sign_q_nxt = value_A[DATA_W-1] ^ value_B[DATA_W-1];
            w_quo_nxt    = w_abs_a;
            w_dvs_nxt    = w_abs_b;
            w_rem_nxt    = '0;
            w_cnt_nxt    = '0;
            w_state_nxt  = StCalc;
          end
        end
      end
      StCalc: begin
        if (!w_trial[DATA_W]) begin
          w_rem_nxt = w_trial[DATA_W-1:0];
          w_quo_nxt = {r_quo[DATA_W-2:0], 1'b1};
        end else begin
          w_rem_nxt = w_shift[DATA_W-1:0];
          w_quo_nxt = {r_quo[DATA_W-2:0], 1'b0};
        end
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == CntW'(DATA_W - 1)) begin
          w_state_nxt = StFin;
        end
      end
      StFin: begin
        w_lo_nxt    = r_sign_q ? (~r_quo + 1'b1) : r_quo;
        w_hi_nxt    = r_sign_a ? (~r_rem + 1'b1) : r_rem;
        w_stop_nxt  = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_sign_a <= 1'b0;
      r_sign_q <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_stop   <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rem    <= w_rem_nxt;
      r_quo    <= w_quo_nxt;
      r_dvs    <= w_dvs_nxt;
      r_sign_a <= w_sign_a_nxt;
      r_sign_q <= w_sign_q_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
      r_stop   <= w_stop_nxt;
      r_zero   <= w_zero_nxt;
    end
  end

  assign busy    = (r_state != StIdle);
  assign divStop = r_stop;
  assign divZero = r_zero;
  assign hi      = r_hi;
  assign lo      = r_lo;

endmodule
